// File: rtl/dither_write_sched_if.sv
// Pixel-in / VRAM-write-out bundle for dither_write_sched.
// The slave modport is the scheduler's view; master is the rasterizer/arbiter side.
interface dither_write_sched_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic          i_ditherOn;
   logic          i_maskSet;
   logic          i_pixValid;
   logic          o_pixReady;
   logic [7:0]    i_r;
   logic [7:0]    i_g;
   logic [7:0]    i_b;
   logic [XW-1:0] i_x;
   logic [YW-1:0] i_y;
   logic          i_flush;
   logic          o_wrValid;
   logic          i_wrReady;
   logic [XW-2:0] o_wrAddrX;
   logic [YW-1:0] o_wrY;
   logic [31:0]   o_wrData;
   logic [1:0]    o_wrBE;
   logic          o_busy;

   modport slave (
      input  i_ditherOn, i_maskSet, i_pixValid, i_r, i_g, i_b, i_x, i_y,
             i_flush, i_wrReady,
      output o_pixReady, o_wrValid, o_wrAddrX, o_wrY, o_wrData, o_wrBE, o_busy
   );

   modport master (
      output i_ditherOn, i_maskSet, i_pixValid, i_r, i_g, i_b, i_x, i_y,
             i_flush, i_wrReady,
      input  o_pixReady, o_wrValid, o_wrAddrX, o_wrY, o_wrData, o_wrBE, o_busy
   );
endinterface

// File: rtl/dither_write_sched.sv
// Dithers RGB888 pixels to BGR555 and packs them into 32-bit VRAM write requests.
// Define PIXEL_PAIR_EN to pair even/odd x pixels; otherwise every pixel is issued alone.
module dither_write_sched #(
   parameter int XW         = 10,
   parameter int YW         = 9,
   parameter int FLUSH_IDLE = 4
) (
   input logic                 clk,
   input logic                 i_nrst,
   dither_write_sched_if.slave bus
);

`ifdef PIXEL_PAIR_EN
   localparam bit PAIR = 1'b1;
`else
   localparam bit PAIR = 1'b0;
`endif
   localparam int IW = (FLUSH_IDLE < 2) ? 1 : $clog2(FLUSH_IDLE);

   typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

   function automatic logic signed [3:0] dith_off(input logic [1:0] xl, input logic [1:0] yl);
      case ({yl, xl})
         4'h0: dith_off = -4'sd4;   4'h1: dith_off =  4'sd0;
         4'h2: dith_off = -4'sd3;   4'h3: dith_off =  4'sd1;
         4'h4: dith_off =  4'sd2;   4'h5: dith_off = -4'sd2;
         4'h6: dith_off =  4'sd3;   4'h7: dith_off = -4'sd1;
         4'h8: dith_off = -4'sd3;   4'h9: dith_off =  4'sd1;
         4'hA: dith_off = -4'sd4;   4'hB: dith_off =  4'sd0;
         4'hC: dith_off =  4'sd3;   4'hD: dith_off = -4'sd1;
         4'hE: dith_off =  4'sd2;   default: dith_off = -4'sd2;
      endcase
   endfunction

   function automatic logic [7:0] clamp8(input logic signed [9:0] v);
      if (v < 10'sd0)        clamp8 = 8'h00;
      else if (v > 10'sd255) clamp8 = 8'hFF;
      else                   clamp8 = v[7:0];
   endfunction

   function automatic logic [4:0] to5(input logic [7:0] c, input logic signed [3:0] off);
      logic signed [9:0] sum;
      sum = $signed({2'b00, c}) + $signed({{6{off[3]}}, off});
      to5 = 5'(clamp8(sum) >> 3);
   endfunction

   state_t          state, state_n;
   logic            s1_vld, s1_dith, s1_mask;
   logic [7:0]      s1_r, s1_g, s1_b;
   logic [XW-1:0]   s1_x;
   logic [YW-1:0]   s1_y;
   logic [31:0]     wr_data;
   logic [1:0]      wr_be, lane_be;
   logic [XW-2:0]   wr_addr;
   logic [YW-1:0]   wr_y;
   logic [IW-1:0]   idle_cnt, idle_n;
   logic            s1_adv, load_new, merge, same_pair, pix_ready, accept;
   logic signed [3:0] off;
   logic [15:0]     pix16;
   state_t          load_tgt;

   // Stage 1 output: dither/clamp of the held pixel
   assign off       = s1_dith ? dith_off(s1_x[1:0], s1_y[1:0]) : 4'sd0;
   assign pix16     = {s1_mask, to5(s1_b, off), to5(s1_g, off), to5(s1_r, off)};
   assign same_pair = (s1_x[XW-1:1] == wr_addr) && (s1_y == wr_y);
   assign lane_be   = s1_x[0] ? 2'b10 : 2'b01;
   assign load_tgt  = PAIR ? HALF : FULL;
   assign pix_ready = !s1_vld || s1_adv;
   assign accept    = bus.i_pixValid && pix_ready;

   always_comb begin
      state_n  = state;
      s1_adv   = 1'b0;
      load_new = 1'b0;
      merge    = 1'b0;
      idle_n   = idle_cnt;
      case (state)
         EMPTY: if (s1_vld) begin
            s1_adv   = 1'b1;
            load_new = 1'b1;
            state_n  = load_tgt;
         end
         HALF: if (s1_vld) begin
            idle_n = '0;
            if (same_pair) begin
               s1_adv = 1'b1;
               merge  = 1'b1;
               if (bus.i_flush || ((wr_be | lane_be) == 2'b11)) state_n = FULL;
            end else begin
               state_n = FULL;
            end
         end else if (bus.i_flush || (idle_cnt == IW'(FLUSH_IDLE - 1))) begin
            state_n = FULL;
            idle_n  = '0;
         end else begin
            idle_n = idle_cnt + 1'b1;
         end
         FULL: if (bus.i_wrReady) begin
            if (s1_vld) begin
               s1_adv   = 1'b1;
               load_new = 1'b1;
               state_n  = load_tgt;
            end else begin
               state_n = EMPTY;
            end
         end
         default: state_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state    <= EMPTY;
         s1_vld   <= 1'b0;
         idle_cnt <= '0;
      end else begin
         state    <= state_n;
         idle_cnt <= idle_n;
         if (pix_ready) s1_vld <= bus.i_pixValid;
      end
   end

   // Stage 0 -> 1 boundary: input capture
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_r    <= bus.i_r;
         s1_g    <= bus.i_g;
         s1_b    <= bus.i_b;
         s1_x    <= bus.i_x;
         s1_y    <= bus.i_y;
         s1_dith <= bus.i_ditherOn;
         s1_mask <= bus.i_maskSet;
      end
   end

   // Stage 1 -> 2 boundary: pair holder contents
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         wr_data <= '0;
         wr_be   <= '0;
         wr_addr <= '0;
         wr_y    <= '0;
      end else if (load_new) begin
         wr_data <= s1_x[0] ? {pix16, 16'h0000} : {16'h0000, pix16};
         wr_be   <= lane_be;
         wr_addr <= s1_x[XW-1:1];
         wr_y    <= s1_y;
      end else if (merge) begin
         wr_be <= wr_be | lane_be;
         if (s1_x[0]) wr_data[31:16] <= pix16;
         else         wr_data[15:0]  <= pix16;
      end
   end

   assign bus.o_pixReady = pix_ready;
   assign bus.o_wrValid  = (state == FULL);
   assign bus.o_wrData   = wr_data;
   assign bus.o_wrBE     = wr_be;
   assign bus.o_wrAddrX  = wr_addr;
   assign bus.o_wrY      = wr_y;
   assign bus.o_busy     = s1_vld || (state != EMPTY);

endmodule

// File: tb/tb_dither_write_sched.sv
// Directed self-checking bench for dither_write_sched; expectations follow PIXEL_PAIR_EN.
module tb_dither_write_sched;
`ifdef PIXEL_PAIR_EN
   localparam bit PAIR = 1'b1;
`else
   localparam bit PAIR = 1'b0;
`endif

   logic clk = 1'b0;
   logic i_nrst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic hs;
   logic [63:0] q[$];
   logic [63:0] exq[$];

   dither_write_sched_if #(.XW(10), .YW(9)) bus ();

   dither_write_sched #(.XW(10), .YW(9), .FLUSH_IDLE(4)) dut (
      .clk   (clk),
      .i_nrst(i_nrst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (i_nrst && bus.o_wrValid && bus.i_wrReady)
         q.push_back({12'h000, bus.o_wrAddrX, bus.o_wrY, bus.o_wrBE, bus.o_wrData});

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk(input int addr, input int y, input logic [1:0] be,
                                      input logic [31:0] d);
      logic [8:0] a9, y9;
      a9 = addr[8:0];
      y9 = y[8:0];
      return {12'h000, a9, y9, be, d};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic dith, input logic mask);
      bus.i_x        = x[9:0];
      bus.i_y        = y[8:0];
      bus.i_r        = r;
      bus.i_g        = g;
      bus.i_b        = b;
      bus.i_ditherOn = dith;
      bus.i_maskSet  = mask;
      bus.i_pixValid = 1'b1;
   endtask

   task automatic wait_accept();
      for (int i = 0; i < 64 && bus.i_pixValid; i++) begin
         @(negedge clk);
         hs = bus.o_pixReady;
         @(posedge clk);
         #1;
         if (hs) bus.i_pixValid = 1'b0;
      end
      chk("accept_timeout", 64'(bus.i_pixValid), 64'd0);
   endtask

   task automatic send(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic dith, input logic mask);
      drive_pix(x, y, r, g, b, dith, mask);
      wait_accept();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && bus.o_busy; i++) begin
         @(posedge clk);
         #1;
      end
      chk("idle_timeout", 64'(bus.o_busy), 64'd0);
   endtask

   task automatic check_q(input string tag);
      chk({tag, "_count"}, 64'(q.size()), 64'(exq.size()));
      for (int i = 0; i < exq.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? q[i] : 64'hDEAD, exq[i]);
      q.delete();
      exq.delete();
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.i_pixValid = 1'b0;
      bus.i_ditherOn = 1'b0;
      bus.i_maskSet  = 1'b0;
      bus.i_r = 8'h00; bus.i_g = 8'h00; bus.i_b = 8'h00;
      bus.i_x = '0;    bus.i_y = '0;
      bus.i_flush    = 1'b0;
      bus.i_wrReady  = 1'b1;
      #12;
      chk("rst_wrValid", 64'(bus.o_wrValid), 64'd0);
      chk("rst_wrData",  64'(bus.o_wrData),  64'd0);
      chk("rst_wrBE",    64'(bus.o_wrBE),    64'd0);
      chk("rst_wrAddrX", 64'(bus.o_wrAddrX), 64'd0);
      chk("rst_wrY",     64'(bus.o_wrY),     64'd0);
      chk("rst_busy",    64'(bus.o_busy),    64'd0);
      chk("rst_pixReady", 64'(bus.o_pixReady), 64'd1);
      cyc();
      i_nrst = 1'b1;
      cyc();

      // T1: dithered 07/07/07 at (2,0),(3,0); cycle N+2 shows the completing lane
      send(2, 0, 8'h07, 8'h07, 8'h07, 1'b1, 1'b0);
      send(3, 0, 8'h07, 8'h07, 8'h07, 1'b1, 1'b0);
      cyc();
      chk("t1_lat_valid", 64'(bus.o_wrValid), 64'd1);
      chk("t1_lat_be",    64'(bus.o_wrBE), PAIR ? 64'd3 : 64'd2);
      chk("t1_lat_data",  64'(bus.o_wrData), 64'h0421_0000);
      wait_idle();
`ifdef PIXEL_PAIR_EN
      exq.push_back(mk(1, 0, 2'b11, 32'h0421_0000));
`else
      exq.push_back(mk(1, 0, 2'b01, 32'h0000_0000));
      exq.push_back(mk(1, 0, 2'b10, 32'h0421_0000));
`endif
      check_q("t1");

      // T2: white with mask at (0,1) clamps to 0xFFFF, issued after the idle window
      send(0, 1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
      cyc(); cyc(); cyc();
      chk("t2_wait_busy",  64'(bus.o_busy), 64'(PAIR));
      chk("t2_wait_valid", 64'(bus.o_wrValid), 64'd0);
      wait_idle();
      exq.push_back(mk(0, 1, 2'b01, 32'h0000_FFFF));
      check_q("t2");

      // T3: (4,0) then (5,1) are different pairs, order kept
      send(4, 0, 8'h08, 8'h10, 8'h18, 1'b0, 1'b0);
      send(5, 1, 8'h08, 8'h10, 8'h18, 1'b0, 1'b0);
      wait_idle();
      exq.push_back(mk(2, 0, 2'b01, 32'h0000_0C41));
      exq.push_back(mk(2, 1, 2'b10, 32'h0C41_0000));
      check_q("t3");

      // T5: dither off vs on for the same pixel
      send(3, 0, 8'h07, 8'h07, 8'h07, 1'b0, 1'b0);
      wait_idle();
      exq.push_back(mk(1, 0, 2'b10, 32'h0000_0000));
      check_q("t5_off");
      send(3, 0, 8'h07, 8'h07, 8'h07, 1'b1, 1'b0);
      wait_idle();
      exq.push_back(mk(1, 0, 2'b10, 32'h0421_0000));
      check_q("t5_on");

      // Flush: a lone pixel leaves early when flushed
      send(6, 2, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
      bus.i_flush = 1'b1;
      cyc();
      cyc();
      chk("flush_valid", 64'(bus.o_wrValid), 64'(PAIR));
      bus.i_flush = 1'b0;
      wait_idle();
      exq.push_back(mk(3, 2, 2'b01, 32'h0000_7FFF));
      check_q("flush");

      // T4: write side stalled 10 cycles with a stream pending
      bus.i_wrReady = 1'b0;
      send(8, 3, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0);
      send(9, 3, 8'h48, 8'h00, 8'h00, 1'b0, 1'b0);
      drive_pix(10, 3, 8'h50, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         hs = bus.i_pixValid & bus.o_pixReady;
         @(posedge clk);
         #1;
         if (hs) bus.i_pixValid = 1'b0;
         chk("t4_valid", 64'(bus.o_wrValid), 64'd1);
         chk("t4_data",  64'(bus.o_wrData), PAIR ? 64'h0009_0008 : 64'h0000_0008);
         chk("t4_be",    64'(bus.o_wrBE), PAIR ? 64'd3 : 64'd1);
         chk("t4_addr",  64'(bus.o_wrAddrX), 64'd4);
         chk("t4_ready", 64'(bus.o_pixReady), 64'd0);
      end
      bus.i_wrReady = 1'b1;
      wait_accept();
      send(11, 3, 8'h58, 8'h00, 8'h00, 1'b0, 1'b0);
      wait_idle();
`ifdef PIXEL_PAIR_EN
      exq.push_back(mk(4, 3, 2'b11, 32'h0009_0008));
      exq.push_back(mk(5, 3, 2'b11, 32'h000B_000A));
`else
      exq.push_back(mk(4, 3, 2'b01, 32'h0000_0008));
      exq.push_back(mk(4, 3, 2'b10, 32'h0009_0000));
      exq.push_back(mk(5, 3, 2'b01, 32'h0000_000A));
      exq.push_back(mk(5, 3, 2'b10, 32'h000B_0000));
`endif
      check_q("t4");

      // T6: reset with the holder and S1 occupied drops everything
      send(0, 4, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
      send(2, 4, 8'h18, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("t6_busy_before", 64'(bus.o_busy), 64'd1);
      i_nrst = 1'b0;
      #1;
      chk("t6_busy",    64'(bus.o_busy), 64'd0);
      chk("t6_wrValid", 64'(bus.o_wrValid), 64'd0);
      cyc();
      cyc();
      i_nrst = 1'b1;
      cyc();
      check_q("t6_dropped");
      send(6, 5, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0);
      wait_idle();
      exq.push_back(mk(3, 5, 2'b01, 32'h0000_0006));
      check_q("t6_restart");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
